// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types and helpers for the pipeline hazard controller.
//   hz_state_t : controller FSM states (RUN, LSTALL, DRAIN, HALTED)
//   PERF_W     : width of the performance counters
//   sel_w()    : forwarding-select width for a given number of forwarding stages
//   cnt_w()    : width of the stall/drain countdown counter
//   perf_inc() : saturating increment for the performance counters
package Pipe_Buf_Reg_PKG;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hz_state_t;

    localparam int unsigned PERF_W = 16;

    // 0 selects the register file, k selects forwarding stage k-1.
    function automatic int unsigned sel_w(input int unsigned fwd_stages);
        return $clog2(fwd_stages + 1);
    endfunction

    // Counter must hold both LOAD_LAT-1 and DRAIN_CYC; never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned load_lat,
                                          input int unsigned drain_cyc);
        int unsigned max_val;
        max_val = (load_lat > drain_cyc) ? load_lat : drain_cyc;
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding priority encoder for one EX operand.
//   rs           : source register of the operand in EX
//   fwd_rd       : destination register per forwarding stage (stage 0 in LSBs)
//   fwd_regwrite : write-enable per forwarding stage
//   sel          : 0 = register file, k = forward from stage k-1 (youngest wins)
module fwd_select #(
    parameter int unsigned RF_ADDRESS = 5,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned SEL_W      = 2
) (
    input  logic [RF_ADDRESS-1:0]            rs,
    input  logic [FWD_STAGES*RF_ADDRESS-1:0] fwd_rd,
    input  logic [FWD_STAGES-1:0]            fwd_regwrite,
    output logic [SEL_W-1:0]                 sel
);

    logic [FWD_STAGES-1:0] hit;

    // Per-stage match; register 0 is hard-wired zero and never forwarded.
    for (genvar k = 0; k < FWD_STAGES; k++) begin : g_hit
        assign hit[k] = fwd_regwrite[k]
                     && (fwd_rd[k*RF_ADDRESS +: RF_ADDRESS] == rs)
                     && (fwd_rd[k*RF_ADDRESS +: RF_ADDRESS] != '0);
    end

    // Scan from the oldest stage down so the lowest index (youngest result) wins.
    always_comb begin
        sel = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/halt flushes,
// operand forwarding selects, halt draining and performance counters.
//   clk, reset                : clock, synchronous active-high reset
//   id_valid, id_rs1, id_rs2  : instruction currently in ID
//   ex_rs1, ex_rs2, ex_rd     : instruction currently in EX
//   ex_memread                : EX instruction is a load
//   fwd_rd, fwd_regwrite      : destination/write-enable per forwarding stage
//   br_taken, halt_req        : EX redirect and halt requests
//   stall                     : hold PC and IF/ID, bubble ID/EX
//   flush_if_id, flush_id_ex  : clear the named pipeline register
//   fwd_a_sel, fwd_b_sel      : operand forwarding selects
//   halted                    : core stopped until reset
//   stall_count, flush_count  : saturating performance counters
module pipe_hazard_ctrl
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int unsigned  RF_ADDRESS = 5,
    parameter int unsigned  FWD_STAGES = 2,
    parameter int unsigned  LOAD_LAT   = 1,
    parameter int unsigned  DRAIN_CYC  = 3,
    localparam int unsigned SEL_W      = sel_w(FWD_STAGES)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            id_valid,
    input  logic [RF_ADDRESS-1:0]           id_rs1,
    input  logic [RF_ADDRESS-1:0]           id_rs2,
    input  logic [RF_ADDRESS-1:0]           ex_rs1,
    input  logic [RF_ADDRESS-1:0]           ex_rs2,
    input  logic [RF_ADDRESS-1:0]           ex_rd,
    input  logic                            ex_memread,
    input  logic [FWD_STAGES*RF_ADDRESS-1:0] fwd_rd,
    input  logic [FWD_STAGES-1:0]           fwd_regwrite,
    input  logic                            br_taken,
    input  logic                            halt_req,
    output logic                            stall,
    output logic                            flush_if_id,
    output logic                            flush_id_ex,
    output logic [SEL_W-1:0]                fwd_a_sel,
    output logic [SEL_W-1:0]                fwd_b_sel,
    output logic                            halted,
    output logic [PERF_W-1:0]               stall_count,
    output logic [PERF_W-1:0]               flush_count
);

    localparam int unsigned     CNT_W        = cnt_w(LOAD_LAT, DRAIN_CYC);
    localparam logic [CNT_W-1:0] LSTALL_LOAD = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYC);
    localparam bit               MULTI_STALL = (LOAD_LAT > 1);

    hz_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             active;
    logic             cnt_last;

    // Load in EX writes a register the ID instruction is about to read.
    assign load_use = id_valid && ex_memread && (ex_rd != '0)
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Branch/halt requests are only honoured while instructions still flow.
    assign active   = (state == RUN) || (state == LSTALL);

    // Countdown reaches zero on this edge (or was already zero).
    assign cnt_last = (cnt <= CNT_W'(1));

    assign halted   = (state == HALTED);

    // Operand forwarding, independent of the FSM.
    fwd_select #(
        .RF_ADDRESS (RF_ADDRESS),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W)
    ) u_fwd_a (
        .rs           (ex_rs1),
        .fwd_rd       (fwd_rd),
        .fwd_regwrite (fwd_regwrite),
        .sel          (fwd_a_sel)
    );

    fwd_select #(
        .RF_ADDRESS (RF_ADDRESS),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W)
    ) u_fwd_b (
        .rs           (ex_rs2),
        .fwd_rd       (fwd_rd),
        .fwd_regwrite (fwd_regwrite),
        .sel          (fwd_b_sel)
    );

    // Same-cycle stall/flush decode; a flush always beats a stall.
    always_comb begin
        stall       = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (active) begin
            if (halt_req || br_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if ((state == LSTALL) || load_use) begin
                stall = 1'b1;
            end
        end else begin
            // DRAIN and HALTED freeze the front end.
            stall = 1'b1;
        end
    end

    // Controller FSM, countdown and performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_req) begin
                        state <= DRAIN;
                        cnt   <= DRAIN_LOAD;
                    end else if (br_taken) begin
                        cnt <= '0;
                    end else if (load_use && MULTI_STALL) begin
                        state <= LSTALL;
                        cnt   <= LSTALL_LOAD;
                    end
                end
                LSTALL: begin
                    if (halt_req) begin
                        state <= DRAIN;
                        cnt   <= DRAIN_LOAD;
                    end else if (br_taken || cnt_last) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_last) begin
                        state <= HALTED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase

            if (stall && (state != HALTED)) begin
                stall_count <= perf_inc(stall_count);
            end
            if (flush_id_ex) begin
                flush_count <= perf_inc(flush_count);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned RA = 5;
    localparam int unsigned FS = 2;
    localparam int unsigned LL = 2;
    localparam int unsigned DC = 3;
    localparam int unsigned SW = $clog2(FS + 1);

    logic              clk;
    logic              reset;
    logic              id_valid;
    logic [RA-1:0]     id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic              ex_memread;
    logic [FS*RA-1:0]  fwd_rd;
    logic [FS-1:0]     fwd_regwrite;
    logic              br_taken, halt_req;
    logic              stall, flush_if_id, flush_id_ex, halted;
    logic [SW-1:0]     fwd_a_sel, fwd_b_sel;
    logic [15:0]       stall_count, flush_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: remaining forced stall cycles, remaining drain cycles, halted flag.
    int m_stall_left = 0;
    int m_drain_left = 0;
    bit m_halted     = 0;
    int m_stall_cnt  = 0;
    int m_flush_cnt  = 0;

    pipe_hazard_ctrl #(
        .RF_ADDRESS (RA),
        .FWD_STAGES (FS),
        .LOAD_LAT   (LL),
        .DRAIN_CYC  (DC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .fwd_rd       (fwd_rd),
        .fwd_regwrite (fwd_regwrite),
        .br_taken     (br_taken),
        .halt_req     (halt_req),
        .stall        (stall),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .halted       (halted),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_load_use();
        return id_valid && ex_memread && (ex_rd != 0)
            && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

    function automatic bit m_frozen();
        return m_halted || (m_drain_left > 0);
    endfunction

    function automatic bit m_stall();
        if (m_frozen()) return 1'b1;
        if (halt_req || br_taken) return 1'b0;
        return (m_stall_left > 0) || m_load_use();
    endfunction

    function automatic bit m_flush();
        return !m_frozen() && (halt_req || br_taken);
    endfunction

    function automatic int m_sel(input logic [RA-1:0] rs);
        logic [RA-1:0] rd;
        for (int k = 0; k < int'(FS); k++) begin
            rd = fwd_rd[k*RA +: RA];
            if (fwd_regwrite[k] && (rd == rs) && (rd != 0)) return k + 1;
        end
        return 0;
    endfunction

    // Compare every output against the model, away from the active edge.
    task automatic sample();
        @(negedge clk);
        chk("stall",       int'(stall),       int'(m_stall()));
        chk("flush_if_id", int'(flush_if_id), int'(m_flush()));
        chk("flush_id_ex", int'(flush_id_ex), int'(m_flush()));
        chk("halted",      int'(halted),      int'(m_halted));
        chk("fwd_a_sel",   int'(fwd_a_sel),   m_sel(ex_rs1));
        chk("fwd_b_sel",   int'(fwd_b_sel),   m_sel(ex_rs2));
        chk("stall_count", int'(stall_count), m_stall_cnt);
        chk("flush_count", int'(flush_count), m_flush_cnt);
    endtask

    // Advance one clock and update the model from the inputs of that cycle.
    task automatic advance();
        bit e_st;
        bit e_fl;
        e_st = m_stall();
        e_fl = m_flush();
        @(posedge clk);
        if (reset) begin
            m_stall_left = 0;
            m_drain_left = 0;
            m_halted     = 0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
        end else begin
            if (e_st && !m_halted && m_stall_cnt < 65535) m_stall_cnt++;
            if (e_fl && m_flush_cnt < 65535) m_flush_cnt++;
            if (m_halted) begin
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (halt_req) begin
                m_drain_left = DC;
                m_stall_left = 0;
            end else if (br_taken) begin
                m_stall_left = 0;
            end else if (m_stall_left > 0) begin
                m_stall_left--;
            end else if (m_load_use()) begin
                m_stall_left = LL - 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0;
        fwd_rd = '0; fwd_regwrite = '0;
        br_taken = 0; halt_req = 0;
    endtask

    task automatic set_load_use();
        id_valid = 1; ex_memread = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd9;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        sample();
        advance();
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        advance();
        advance();
        reset = 0;

        // Reset state with idle inputs
        sample();
        chk("rst_stall", int'(stall), 0);
        chk("rst_flush", int'(flush_id_ex), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_stall_count", int'(stall_count), 0);
        chk("rst_flush_count", int'(flush_count), 0);
        advance();

        // Load-use with LOAD_LAT=2: two stall cycles
        set_load_use();
        sample();
        chk("lu_stall_c0", int'(stall), 1);
        advance();
        ex_memread = 0;
        sample();
        chk("lu_stall_c1", int'(stall), 1);
        advance();
        idle();
        sample();
        chk("lu_stall_c2", int'(stall), 0);
        chk("lu_stall_count", int'(stall_count), 2);
        advance();

        // Forwarding priority and register-zero exclusion
        fwd_rd = {5'd7, 5'd7}; fwd_regwrite = 2'b11; ex_rs1 = 5'd7; ex_rs2 = 5'd0;
        sample();
        chk("fwd_a_both", int'(fwd_a_sel), 1);
        chk("fwd_b_none", int'(fwd_b_sel), 0);
        advance();
        fwd_regwrite = 2'b10; ex_rs2 = 5'd7;
        sample();
        chk("fwd_a_stage1", int'(fwd_a_sel), 2);
        chk("fwd_b_stage1", int'(fwd_b_sel), 2);
        advance();
        fwd_rd = '0; fwd_regwrite = 2'b11; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        sample();
        chk("fwd_a_zero", int'(fwd_a_sel), 0);
        advance();

        // Load-use together with a taken branch: flush wins
        do_reset();
        set_load_use();
        br_taken = 1;
        sample();
        chk("bl_stall", int'(stall), 0);
        chk("bl_flush_if", int'(flush_if_id), 1);
        chk("bl_flush_ex", int'(flush_id_ex), 1);
        advance();
        idle();
        sample();
        chk("bl_after_stall", int'(stall), 0);
        chk("bl_flush_count", int'(flush_count), 1);
        advance();

        // Halt: one flush cycle, three drain cycles, then halted
        do_reset();
        halt_req = 1;
        sample();
        chk("halt_flush", int'(flush_id_ex), 1);
        advance();
        halt_req = 0;
        for (int i = 0; i < int'(DC); i++) begin
            sample();
            chk("drain_stall", int'(stall), 1);
            chk("drain_flush", int'(flush_if_id), 0);
            chk("drain_halted", int'(halted), 0);
            advance();
        end
        sample();
        chk("halted_set", int'(halted), 1);
        chk("halted_stall_count", int'(stall_count), 3);
        advance();
        br_taken = 1;
        sample();
        chk("halted_no_flush", int'(flush_id_ex), 0);
        chk("halted_stall", int'(stall), 1);
        advance();
        idle();
        sample();
        chk("halted_flush_count", int'(flush_count), 1);
        advance();

        // Reset asserted during DRAIN
        do_reset();
        halt_req = 1;
        sample();
        advance();
        halt_req = 0;
        sample();
        advance();
        reset = 1;
        sample();
        advance();
        reset = 0;
        sample();
        chk("rd_halted", int'(halted), 0);
        chk("rd_stall", int'(stall), 0);
        chk("rd_stall_count", int'(stall_count), 0);
        chk("rd_flush_count", int'(flush_count), 0);
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            reset        = ($urandom_range(0, 59) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rs1       = 5'($urandom_range(0, 3));
            ex_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_memread   = ($urandom_range(0, 2) == 0);
            fwd_rd       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_regwrite = 2'($urandom);
            br_taken     = ($urandom_range(0, 9) == 0);
            halt_req     = ($urandom_range(0, 49) == 0);
            sample();
            advance();
        end
        reset = 0;

        // Continuous load-use stalls past the counter range
        do_reset();
        set_load_use();
        for (int c = 0; c < 70000; c++) begin
            sample();
            advance();
        end
        sample();
        chk("sat_stall_count", int'(stall_count), 16'hFFFF);
        chk("sat_flush_count", int'(flush_count), 0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RF_ADDRESS, default 5, register-specifier width.
REQ-002 SHALL have parameter FWD_STAGES, default 2, number of downstream stages that can forward (index 0 = EX/MEM, 1 = MEM/WB, ...).
REQ-003 SHALL have parameter LOAD_LAT, default 1, range 1..7; stall cycles inserted per load-use hazard.
REQ-004 SHALL have parameter DRAIN_CYC, default 3; cycles allowed for older instructions to retire after a halt.
REQ-005 SHALL have localparam SEL_W = $clog2(FWD_STAGES+1).
REQ-006 Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  RF_ADDRESS  source registers in ID.
- ex_rs1, ex_rs2  in  RF_ADDRESS  source registers in EX.
- ex_rd  in  RF_ADDRESS  destination register in EX.
- ex_memread  in  1  EX instruction is a load.
- fwd_rd  in  FWD_STAGES*RF_ADDRESS  destination register per forwarding stage.
- fwd_regwrite  in  FWD_STAGES  write-enable per forwarding stage.
- br_taken  in  1  EX resolved a taken branch or jump.
- halt_req  in  1  EX holds a halt instruction.
- stall  out  1  hold PC and IF/ID; bubble ID/EX.
- flush_if_id, flush_id_ex  out  1  clear the named pipeline register.
- fwd_a_sel, fwd_b_sel  out  SEL_W  0 = register file; k = stage k-1.
- halted  out  1  core is stopped.
- stall_count, flush_count  out  16  performance counters.

Function
REQ-007 Load-use hazard SHALL be detected when id_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-008 FSM states SHALL be RUN, LSTALL, DRAIN and HALTED.
REQ-009 In RUN, a hazard SHALL assert stall combinationally in the same cycle; if LOAD_LAT>1, the FSM SHALL enter LSTALL with a counter loaded to LOAD_LAT-1.
REQ-010 In LSTALL, stall SHALL stay high; the counter SHALL decrement each cycle, and the FSM SHALL return to RUN on the cycle the counter reaches 0 (total stall = LOAD_LAT cycles).
REQ-011 Forwarding select for operand A SHALL be the lowest index k with fwd_regwrite[k] & fwd_rd[k]==ex_rs1 & fwd_rd[k]!=0, output as k+1, else 0; operand B SHALL follow the same rule using ex_rs2; purely combinational.
REQ-012 br_taken in RUN or LSTALL SHALL assert flush_if_id and flush_id_ex for that cycle, force stall=0, and return the FSM to RUN with the counter cleared (flush beats stall).
REQ-013 halt_req in RUN or LSTALL SHALL assert both flushes that cycle and enter DRAIN with the counter set to DRAIN_CYC; halt_req takes priority over simultaneous br_taken.
REQ-014 In DRAIN, stall SHALL be 1 and the flush outputs 0; on counter==0 the FSM SHALL enter HALTED.
REQ-015 HALTED SHALL be left only by reset; halted=1 and stall=1 there, and br_taken/halt_req are ignored.
REQ-016 stall_count SHALL increment on every cycle with stall=1 while not HALTED; flush_count SHALL increment on every cycle with flush_id_ex=1; both saturate at 16'hFFFF.

Reset
REQ-017 On reset: FSM=RUN, counter=0, stall_count=0, flush_count=0; stall, flushes and halted read 0 in the cycle after reset unless a hazard input is present.
REQ-018 Reset asserted mid-LSTALL or mid-DRAIN SHALL abort that state on the next edge.

Structure
REQ-019 The state enum and SEL_W helper SHALL live in Pipe_Buf_Reg_PKG.
REQ-020 Forwarding priority SHALL be one sub-module, fwd_select, instantiated twice (A and B).

Verification
REQ-021 ex_memread=1, ex_rd=5, id_rs1=5, LOAD_LAT=2 -> stall high for exactly 2 cycles, stall_count=2.
REQ-022 fwd_rd={stage1:7, stage0:7}, both write, ex_rs1=7 -> fwd_a_sel=1; ex_rs1=0 with rd=0 -> sel 0.
REQ-023 Load-use hazard plus br_taken in the same cycle -> stall=0, both flushes=1, flush_count=1, FSM=RUN.
REQ-024 halt_req, DRAIN_CYC=3 -> flushes for 1 cycle, halted=1 four cycles later; later br_taken causes no flush.
REQ-025 Reset asserted during DRAIN -> FSM=RUN, halted=0, counters 0 on the next edge.
REQ-026 Forced 70000 stall cycles -> stall_count holds at 16'hFFFF.
